// File: rtl/fod_phase_acc_pkg.sv
// Shared constants for the FOD phase accumulator and its downstream product stage.
// Holds the fractional width, DTC-path widths, PHE width helper and dither LFSR constants.
package fod_phase_acc_pkg;

  localparam int FOD_WF      = 16;
  localparam int FOD_DTC_WI  = 13;
  localparam int FOD_DTC_WIB = 3;

  // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: feedback from bits 0,2,3,5
  localparam logic [15:0] FOD_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] FOD_LFSR_TAPS = 16'h002D;

  function automatic int fod_phe_width(input int wib, input int wf);
    return wib + wf;
  endfunction

  function automatic logic [15:0] fod_lfsr_step(input logic [15:0] state);
    logic fb;
    fb = ^(state & FOD_LFSR_TAPS);
    return {fb, state[15:1]};
  endfunction

endpackage

// File: rtl/fod_dly_line.sv
// Parameterised W-bit, D-stage register pipeline with async active-low reset and sync clear.
module fod_dly_line
#(
  parameter int W = 1,
  parameter int D = 2
)
(
  input  logic         CLK,
  input  logic         NRST,
  input  logic         SYNC_CLR,
  input  logic [W-1:0] DIN,
  output logic [W-1:0] DOUT
);

  logic [W-1:0] stage_q [D];
  logic [W-1:0] stage_d [D];

  always_comb begin
    for (int i = 0; i < D; i++) begin
      stage_d[i] = '0;
    end
    if (!SYNC_CLR) begin
      stage_d[0] = DIN;
      for (int i = 1; i < D; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      for (int i = 0; i < D; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign DOUT = stage_q[D-1];

endmodule

// File: rtl/fod_phase_acc.sv
// Fractional-N phase accumulator: issues divide ratio, centred phase residue and delayed copies.
// Optional LFSR carry-in dither is enabled by defining FOD_PHACC_DITHER_EN.
module fod_phase_acc
  import fod_phase_acc_pkg::*;
#(
  parameter int WI   = 8,
  parameter int WF   = FOD_WF,
  parameter int WIB  = 3,
  parameter int NMIN = 2,
  parameter int DLY  = 2
)
(
  input  logic                               NRST,
  input  logic                               CLK,
  input  logic                               EN,
  input  logic                               SYNC_CLR,
  input  logic [WI+WF-1:0]                   FCW_IN,
  input  logic                               FCW_LD,
  output logic [WI:0]                        DIV_N,
  output logic [fod_phe_width(WIB,WF)-1:0]   PHE_S,
  output logic                               VALID,
  output logic [WI:0]                        DIV_N_DLY,
  output logic                               VALID_DLY,
  output logic                               FCW_ERR
);

  localparam int PW = fod_phe_width(WIB, WF);
  localparam logic [WI-1:0] NMIN_V   = WI'(NMIN);
  localparam logic [PW-1:0] PHE_HALF = {{WIB{1'b0}}, 1'b1, {(WF-1){1'b0}}};

  logic [WI-1:0] fcw_int_q,  fcw_int_d;
  logic [WF-1:0] fcw_frac_q, fcw_frac_d;
  logic [WF-1:0] acc_q,      acc_d;
  logic [WI:0]   div_n_q,    div_n_d;
  logic [PW-1:0] phe_q,      phe_d;
  logic          valid_q,    valid_d;
  logic          fcw_err_q,  fcw_err_d;

  logic [WF:0]   sum;
  logic [WI-1:0] ld_int;
  logic          ld_low;
  logic          cin;

`ifdef FOD_PHACC_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (SYNC_CLR) begin
      lfsr_d = FOD_LFSR_SEED;
    end else if (EN) begin
      lfsr_d = fod_lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      lfsr_q <= FOD_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign cin = lfsr_q[0];
`else
  assign cin = 1'b0;
`endif

  // The addition always uses the FCW active before this edge; a load lands after it.
  always_comb begin
    ld_int     = FCW_IN[WI+WF-1:WF];
    ld_low     = (ld_int < NMIN_V);
    sum        = {1'b0, acc_q} + {1'b0, fcw_frac_q} + {{WF{1'b0}}, cin};

    acc_d      = acc_q;
    div_n_d    = div_n_q;
    phe_d      = phe_q;
    valid_d    = 1'b0;
    fcw_int_d  = fcw_int_q;
    fcw_frac_d = fcw_frac_q;
    fcw_err_d  = fcw_err_q;

    if (SYNC_CLR) begin
      acc_d   = '0;
      div_n_d = '0;
      phe_d   = '0;
    end else if (EN) begin
      acc_d   = sum[WF-1:0];
      div_n_d = {1'b0, fcw_int_q} + {{WI{1'b0}}, sum[WF]};
      phe_d   = {{WIB{1'b0}}, sum[WF-1:0]} - PHE_HALF;
      valid_d = 1'b1;
    end

    if (FCW_LD) begin
      fcw_int_d  = ld_low ? NMIN_V : ld_int;
      fcw_frac_d = FCW_IN[WF-1:0];
      fcw_err_d  = fcw_err_q | ld_low;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      fcw_int_q  <= '0;
      fcw_frac_q <= '0;
      acc_q      <= '0;
      div_n_q    <= '0;
      phe_q      <= '0;
      valid_q    <= 1'b0;
      fcw_err_q  <= 1'b0;
    end else begin
      fcw_int_q  <= fcw_int_d;
      fcw_frac_q <= fcw_frac_d;
      acc_q      <= acc_d;
      div_n_q    <= div_n_d;
      phe_q      <= phe_d;
      valid_q    <= valid_d;
      fcw_err_q  <= fcw_err_d;
    end
  end

  assign DIV_N   = div_n_q;
  assign PHE_S   = phe_q;
  assign VALID   = valid_q;
  assign FCW_ERR = fcw_err_q;

  fod_dly_line #(.W(WI+1), .D(DLY)) u_div_dly (
    .CLK      (CLK),
    .NRST     (NRST),
    .SYNC_CLR (SYNC_CLR),
    .DIN      (div_n_q),
    .DOUT     (DIV_N_DLY)
  );

  fod_dly_line #(.W(1), .D(DLY)) u_valid_dly (
    .CLK      (CLK),
    .NRST     (NRST),
    .SYNC_CLR (SYNC_CLR),
    .DIN      (valid_q),
    .DOUT     (VALID_DLY)
  );

endmodule

// File: tb/tb_fod_phase_acc.sv
// Self-checking bench for fod_phase_acc: directed tables, corner sequences and random traffic
// against an arithmetic reference model (LFSR carry-in modelled when FOD_PHACC_DITHER_EN is set).
module tb_fod_phase_acc;

  localparam int WI  = 8;
  localparam int WF  = 16;
  localparam int WIB = 3;
  localparam int DLY = 2;

  logic              NRST;
  logic              CLK;
  logic              EN;
  logic              SYNC_CLR;
  logic [WI+WF-1:0]  FCW_IN;
  logic              FCW_LD;
  logic [WI:0]       DIV_N;
  logic [WIB+WF-1:0] PHE_S;
  logic              VALID;
  logic [WI:0]       DIV_N_DLY;
  logic              VALID_DLY;
  logic              FCW_ERR;

  int errors = 0;
  int checks = 0;

  fod_phase_acc #(.WI(WI), .WF(WF), .WIB(WIB), .NMIN(2), .DLY(DLY)) dut (
    .NRST      (NRST),
    .CLK       (CLK),
    .EN        (EN),
    .SYNC_CLR  (SYNC_CLR),
    .FCW_IN    (FCW_IN),
    .FCW_LD    (FCW_LD),
    .DIV_N     (DIV_N),
    .PHE_S     (PHE_S),
    .VALID     (VALID),
    .DIV_N_DLY (DIV_N_DLY),
    .VALID_DLY (VALID_DLY),
    .FCW_ERR   (FCW_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state: plain integers, FCW as int/frac numbers, delay as a history queue.
  int          m_acc, m_int, m_frac, m_div, m_phe;
  bit          m_valid, m_err;
  int          m_hist_div[$];
  bit          m_hist_val[$];
  logic [15:0] m_lfsr;

  task automatic model_reset();
    m_acc = 0; m_int = 0; m_frac = 0; m_div = 0; m_phe = 0;
    m_valid = 0; m_err = 0;
    m_hist_div.delete();
    m_hist_val.delete();
    for (int i = 0; i < DLY; i++) begin
      m_hist_div.push_back(0);
      m_hist_val.push_back(0);
    end
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_edge(input bit en, input bit clr, input bit ld, input int fcw);
    int sum;
    int cin;
    if (clr) begin
      for (int i = 0; i < DLY; i++) begin
        m_hist_div[i] = 0;
        m_hist_val[i] = 0;
      end
    end else begin
      m_hist_div.push_back(m_div);
      m_hist_val.push_back(m_valid);
      void'(m_hist_div.pop_front());
      void'(m_hist_val.pop_front());
    end
    cin = 0;
`ifdef FOD_PHACC_DITHER_EN
    cin = int'(m_lfsr[0]);
`endif
    if (clr) begin
      m_acc = 0; m_div = 0; m_phe = 0; m_valid = 0;
      m_lfsr = 16'hACE1;
    end else if (en) begin
      sum     = m_acc + m_frac + cin;
      m_acc   = sum % 65536;
      m_div   = m_int + sum / 65536;
      m_phe   = m_acc - 32768;
      m_valid = 1;
      m_lfsr  = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end else begin
      m_valid = 0;
    end
    if (ld) begin
      m_int  = fcw / 65536;
      m_frac = fcw % 65536;
      if (m_int < 2) begin
        m_int = 2;
        m_err = 1;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, ".div_n"},     int'(DIV_N),           m_div);
    check({tag, ".phe_s"},     int'($signed(PHE_S)),  m_phe);
    check({tag, ".valid"},     int'(VALID),           int'(m_valid));
    check({tag, ".div_n_dly"}, int'(DIV_N_DLY),       m_hist_div[0]);
    check({tag, ".valid_dly"}, int'(VALID_DLY),       int'(m_hist_val[0]));
    check({tag, ".fcw_err"},   int'(FCW_ERR),         int'(m_err));
  endtask

  task automatic apply_stimulus(input bit en, input bit clr, input bit ld, input int fcw,
                                input string tag);
    EN       = en;
    SYNC_CLR = clr;
    FCW_LD   = ld;
    FCW_IN   = fcw[WI+WF-1:0];
    @(posedge CLK);
    model_edge(en, clr, ld, fcw);
    #1;
    check_output(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".div_n"},     int'(DIV_N),     0);
    check({tag, ".phe_s"},     int'(PHE_S),     0);
    check({tag, ".valid"},     int'(VALID),     0);
    check({tag, ".div_n_dly"}, int'(DIV_N_DLY), 0);
    check({tag, ".valid_dly"}, int'(VALID_DLY), 0);
    check({tag, ".fcw_err"},   int'(FCW_ERR),   0);
  endtask

  typedef struct {
    bit en;
    bit ld;
    int fcw;
    int exp_div;
    int exp_phe;
    bit exp_valid;
    bit exp_vdly;
    int exp_ddly;
  } vec_t;

  vec_t tbl[9];

  int tog_en  [6];
  int tog_phe [6];
  int tog_div [6];
  int tog_val [6];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // FCW 4.25: divide ratio 4,4,4,5 and residue -0x4000,0,+0x4000,-0x8000
    tbl[0] = '{en:0, ld:1, fcw:32'h044000, exp_div:0, exp_phe:0,      exp_valid:0, exp_vdly:0, exp_ddly:0};
    tbl[1] = '{en:1, ld:0, fcw:0, exp_div:4, exp_phe:-16384, exp_valid:1, exp_vdly:0, exp_ddly:0};
    tbl[2] = '{en:1, ld:0, fcw:0, exp_div:4, exp_phe:0,      exp_valid:1, exp_vdly:0, exp_ddly:0};
    tbl[3] = '{en:1, ld:0, fcw:0, exp_div:4, exp_phe:16384,  exp_valid:1, exp_vdly:1, exp_ddly:4};
    tbl[4] = '{en:1, ld:0, fcw:0, exp_div:5, exp_phe:-32768, exp_valid:1, exp_vdly:1, exp_ddly:4};
    tbl[5] = '{en:1, ld:0, fcw:0, exp_div:4, exp_phe:-16384, exp_valid:1, exp_vdly:1, exp_ddly:4};
    tbl[6] = '{en:1, ld:0, fcw:0, exp_div:4, exp_phe:0,      exp_valid:1, exp_vdly:1, exp_ddly:5};
    tbl[7] = '{en:1, ld:0, fcw:0, exp_div:4, exp_phe:16384,  exp_valid:1, exp_vdly:1, exp_ddly:4};
    tbl[8] = '{en:1, ld:0, fcw:0, exp_div:5, exp_phe:-32768, exp_valid:1, exp_vdly:1, exp_ddly:4};

    tog_en  = '{1, 0, 0, 1, 1, 1};
    tog_phe = '{-16384, -16384, -16384, 0, 16384, -32768};
    tog_div = '{4, 4, 4, 4, 4, 5};
    tog_val = '{1, 0, 0, 1, 1, 1};

    NRST = 1'b0; EN = 1'b0; SYNC_CLR = 1'b0; FCW_LD = 1'b0; FCW_IN = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    @(negedge CLK);
    NRST = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(tbl[i].en, 1'b0, tbl[i].ld, tbl[i].fcw, $sformatf("tbl%0d", i));
`ifndef FOD_PHACC_DITHER_EN
      check($sformatf("tbl%0d.div", i),   int'(DIV_N),          tbl[i].exp_div);
      check($sformatf("tbl%0d.phe", i),   int'($signed(PHE_S)), tbl[i].exp_phe);
      check($sformatf("tbl%0d.valid", i), int'(VALID),          int'(tbl[i].exp_valid));
      check($sformatf("tbl%0d.vdly", i),  int'(VALID_DLY),      int'(tbl[i].exp_vdly));
      check($sformatf("tbl%0d.ddly", i),  int'(DIV_N_DLY),      tbl[i].exp_ddly);
`endif
    end

    // Clamp: 1.5 loads as 2.5 and sets the sticky error
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h018000, "clamp_ld");
    check("clamp.err_set", int'(FCW_ERR), 1);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 0, "clamp_run");
      check("clamp.err_held", int'(FCW_ERR), 1);
`ifndef FOD_PHACC_DITHER_EN
      check("clamp.div", int'(DIV_N), (i % 2 == 0) ? 2 : 3);
`endif
    end
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h050000, "clamp_reload");
    check("clamp.err_sticky", int'(FCW_ERR), 1);

    // Asynchronous reset in the middle of a cycle
    @(posedge CLK);
    model_edge(EN, SYNC_CLR, FCW_LD, int'(FCW_IN));
    #3;
    NRST = 1'b0;
    #1;
    model_reset();
    check_all_zero("midreset");
    @(negedge CLK);
    NRST = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 0, "post_reset");
`ifndef FOD_PHACC_DITHER_EN
    check("post_reset.phe", int'($signed(PHE_S)), -32768);
    check("post_reset.div", int'(DIV_N), 0);
`endif

    // SYNC_CLR together with an FCW load at acc = 0xC000
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h044000, "clr_prep");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 0, "clr_acc");
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h060000, "clr_ld");
    check("clr.valid", int'(VALID), 0);
    check("clr.div",   int'(DIV_N), 0);
    check("clr.phe",   int'(PHE_S), 0);
    check("clr.vdly",  int'(VALID_DLY), 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 0, "clr_resume");
`ifndef FOD_PHACC_DITHER_EN
      check("clr_resume.div", int'(DIV_N), 6);
      check("clr_resume.phe", int'($signed(PHE_S)), -32768);
`endif
    end

    // EN gaps hold the accumulator without losing the carry
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h044000, "tog_prep");
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(tog_en[i] != 0, 1'b0, 1'b0, 0, "tog");
      check("tog.valid", int'(VALID), tog_val[i]);
`ifndef FOD_PHACC_DITHER_EN
      check("tog.phe", int'($signed(PHE_S)), tog_phe[i]);
      check("tog.div", int'(DIV_N), tog_div[i]);
`endif
    end

    // Integer FCW: constant ratio without dither, LFSR-driven 5s with it
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h040000, "int_prep");
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 0, "int_fcw");
`ifndef FOD_PHACC_DITHER_EN
      check("int_fcw.div", int'(DIV_N), 4);
`endif
    end

    for (int i = 0; i < 400; i++) begin
      bit en, clr, ld;
      int fcw;
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) fcw = int'($urandom_range(0, 32'h01FFFF));
      else fcw = int'($urandom & 32'h00FFFFFF);
      apply_stimulus(en, clr, ld, fcw, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fod_phase_acc.md
Name: fod_phase_acc

Overview:
Fractional-N phase accumulator for the FOD datapath; sits directly upstream of the signed fixed-point product stage.
- Per enabled CLK, accumulates the fractional part of a frequency control word (FCW) and issues the integer divide ratio (integer part + carry).
- Emits the centred signed phase residue that the product stage scales by the DTC gain.
- Provides delayed copies of ratio and valid, aligned to the product stage's 2-cycle latency.

Parameters:
WI, 8, FCW integer width (unsigned)
WF, 16, FCW / accumulator fractional width
WIB, 3, signed integer width of PHE_S (sign included); must be >= 2
NMIN, 2, minimum legal FCW integer part
DLY, 2, alignment delay in CLK cycles for DIV_N_DLY / VALID_DLY

Ports:
NRST  in  1  asynchronous active-low reset
CLK  in  1  clock
EN  in  1  accumulate enable
SYNC_CLR  in  1  synchronous clear of accumulator and pipeline
FCW_IN  in  WI+WF  unsigned FCW {int, frac}
FCW_LD  in  1  one-cycle load strobe for FCW_IN
DIV_N  out  WI+1  integer divide ratio this cycle
PHE_S  out  WIB+WF  signed residue, acc - 0.5, WF fractional bits
VALID  out  1  DIV_N / PHE_S valid
DIV_N_DLY  out  WI+1  DIV_N delayed DLY cycles
VALID_DLY  out  1  VALID delayed DLY cycles, qualifies downstream product
FCW_ERR  out  1  sticky flag: loaded FCW integer part < NMIN

Behaviour:
- Reset is NRST, asynchronous, active-low; clock is CLK.
- All outputs reset to 0: DIV_N, PHE_S, VALID, DIV_N_DLY, VALID_DLY, FCW_ERR. Accumulator and active FCW also reset to 0.
- FCW load: FCW_LD=1 latches FCW_IN into the active FCW at that edge. It is used from the next accumulation onward and is never applied mid-addition.
- FCW clamp: if FCW_IN integer part < NMIN, the active integer part is set to NMIN, the fraction is taken as-is, and FCW_ERR is set. FCW_ERR clears only on NRST.
- Accumulation: on an edge with EN=1, {carry, acc} = acc + frac_active, modulo 2^WF, with carry = bit WF.
  - DIV_N <= int_active + carry (WI+1 bits, no overflow).
  - PHE_S <= sign-extended {0, acc_new} - 2^(WF-1), using the new acc value.
  - VALID <= 1.
  - Latency: 1 cycle from the EN edge.
- EN=0: acc, DIV_N and PHE_S hold; VALID <= 0.
- Delay line: DIV_N and VALID pass through a DLY-stage shift register to DIV_N_DLY and VALID_DLY. It shifts every cycle, independent of EN.
- Priority: SYNC_CLR > FCW_LD > EN.
  - SYNC_CLR zeroes acc, DIV_N, PHE_S, VALID and all delay stages. FCW_ERR and the active FCW are retained.
  - An FCW_LD in the same cycle still loads.
  - No accumulation occurs in a SYNC_CLR cycle.
- FCW_LD with EN=1 in the same cycle: that cycle's accumulation uses the old FCW; the new FCW applies next cycle.
- frac_active = 0: carry is never generated, DIV_N = int_active, PHE_S is constant.
- Wrap-around: acc overflow is the carry and is never saturated. PHE_S range is [-2^(WF-1), 2^(WF-1)-1] LSBs.
- Reset mid-operation: NRST asserted clears everything asynchronously. The first accumulation after release starts from acc = 0.

Optional Feature:
Macro FOD_PHACC_DITHER_EN.
- Defined: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) steps on every EN=1 cycle. Its output bit is used as the carry-in of the accumulator addition. The LFSR resets to the seed on NRST and on SYNC_CLR.
- Undefined: carry-in is 0; behaviour is exactly as above, with no LFSR logic.

Decomposition:
- Shared package: the WF constant (16, common to the product stage), the PHE width formula WIB+WF, the DTC-path integer widths (13/3), and the LFSR seed/taps constants.
- One natural sub-module: fod_dly_line, a parameterised width/depth register pipeline with async reset and sync clear. It is instantiated twice: DIV_N with width WI+1, and VALID with width 1.

Test Plan:
- FCW_IN=4.25 (int 4, frac 0x4000), FCW_LD then EN=1 continuously -> DIV_N 4,4,4,5 repeating; PHE_S -0x4000, 0x0000, +0x4000, -0x8000 repeating; VALID high one cycle after EN.
- Same stimulus -> DIV_N_DLY equals DIV_N delayed exactly 2 cycles; VALID_DLY rises 3 cycles after the first EN edge.
- FCW_IN=1.5 -> active int clamped to 2, FCW_ERR=1 and held; DIV_N 2,3,2,3; FCW_ERR cleared only by NRST.
- Accumulating at acc=0xC000, assert SYNC_CLR and FCW_LD (FCW=6.0) together -> next cycle VALID=0, DIV_N=0, PHE_S=0, VALID_DLY=0. On resumed EN: DIV_N=6, PHE_S=-0x8000 constant.
- EN toggled 1,0,0,1 with FCW 4.25 -> acc and PHE_S hold during EN=0; VALID low for 2 cycles; sequence resumes without a skipped carry.
- With FOD_PHACC_DITHER_EN, FCW=4.0 -> DIV_N shows occasional 5s matching the LFSR bit sequence from 0xACE1. Without the macro -> DIV_N constantly 4.
